// File: rtl/parallel_to_serial_shift_register_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: FSM states and
// the bit-count width helper.
package parallel_to_serial_shift_register_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a counter that must index bits 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/parallel_to_serial_shift_register_shift_bit_counter.sv
// Bit position counter for one serial frame: tracks which bit is on the line
// and flags the first and last positions.
module shift_bit_counter
  import parallel_to_serial_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic advance_i,
  output logic is_first_o,
  output logic is_last_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (advance_i && (count_q != LAST)) begin
      // Saturates at the last position so the count never exceeds WIDTH-1.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_first_o = (count_q == '0);
  assign is_last_o  = (count_q == LAST);

endmodule

// File: rtl/parallel_to_serial_shift_register.sv
// Parallel-to-serial transmitter with valid/ready load and a one-word holding
// buffer so consecutive frames are emitted without an idle bit between them.
module parallel_to_serial_shift_register
  import parallel_to_serial_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_last
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_full_q, buf_full_d;

  logic               accept;
  logic               cnt_clear;
  logic               cnt_advance;
  logic               is_first;
  logic               is_last;
  logic               shifting;
  logic [WIDTH-1:0]   shifted;

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .clear_i    (cnt_clear),
    .advance_i  (cnt_advance),
    .is_first_o (is_first),
    .is_last_o  (is_last)
  );

  assign load_ready = !buf_full_q;
  assign accept     = load_valid && load_ready;
  assign shifting   = (state_q == ST_SHIFT);

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
      assign out     = shifting && shreg_q[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
      assign out     = shifting && shreg_q[0];
    end
  endgenerate

  assign out_valid   = shifting;
  assign frame_start = shifting && is_first;
  assign frame_last  = shifting && is_last;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shreg_d   = data_in;
          cnt_clear = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (enable && !is_last) begin
          shreg_d     = shifted;
          cnt_advance = 1'b1;
        end else if (enable) begin
          // Frame end: buffered word first, else bypass a same-cycle accept.
          if (buf_full_q) begin
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
            cnt_clear  = 1'b1;
          end else if (accept) begin
            shreg_d   = data_in;
            cnt_clear = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            shreg_d   = '0;
            cnt_clear = 1'b1;
          end
        end

        if (accept && !(enable && is_last)) begin
          buf_d      = data_in;
          buf_full_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_shift_register.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a word-queue model of the serial stream.
module tb_parallel_to_serial_shift_register;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;

  logic m_ready, m_out, m_valid, m_fs, m_fl;
  logic l_ready, l_out, l_valid, l_fs, l_fl;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  parallel_to_serial_shift_register #(
    .WIDTH     (W),
    .MSB_FIRST (1'b1)
  ) u_msb (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (m_ready),
    .out         (m_out),
    .out_valid   (m_valid),
    .frame_start (m_fs),
    .frame_last  (m_fl)
  );

  parallel_to_serial_shift_register #(
    .WIDTH     (W),
    .MSB_FIRST (1'b0)
  ) u_lsb (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .data_in     (data_in),
    .load_valid  (load_valid),
    .load_ready  (l_ready),
    .out         (l_out),
    .out_valid   (l_valid),
    .frame_start (l_fs),
    .frame_last  (l_fl)
  );

  // Model: q holds the word on the line (head) plus at most one waiting word;
  // pos is the index (in transmission order) of the bit on the line.
  logic [W-1:0] q[$];
  int unsigned  pos = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        pos = 0;
      end else begin
        logic acc;
        acc = load_valid && (q.size() < 2);
        if ((q.size() > 0) && enable) begin
          pos++;
          if (pos == W) begin
            void'(q.pop_front());
            pos = 0;
          end
        end
        if (acc) q.push_back(data_in);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic v;
    logic om;
    logic ol;
    logic fs;
    logic fl;
    logic lr;
  } tr_t;

  tr_t tr[$];

  initial begin
    forever begin
      logic         ev;
      logic [W-1:0] hd;
      @(negedge clk);
      tr.push_back('{m_valid, m_out, l_out, m_fs, m_fl, m_ready});
      ev = (q.size() > 0);
      hd = ev ? q[0] : '0;
      chk("m_valid", 32'(m_valid), 32'(ev));
      chk("l_valid", 32'(l_valid), 32'(ev));
      chk("m_out",   32'(m_out),   32'(ev && hd[W-1-pos]));
      chk("l_out",   32'(l_out),   32'(ev && hd[pos]));
      chk("m_fs",    32'(m_fs),    32'(ev && pos == 0));
      chk("l_fs",    32'(l_fs),    32'(ev && pos == 0));
      chk("m_fl",    32'(m_fl),    32'(ev && pos == W-1));
      chk("l_fl",    32'(l_fl),    32'(ev && pos == W-1));
      chk("m_ready", 32'(m_ready), 32'(q.size() < 2));
      chk("l_ready", 32'(l_ready), 32'(q.size() < 2));
    end
  end

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    tr.delete();
    data_in    = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  logic [0:7] exp_m;
  logic [0:7] exp_l;
  int unsigned stall_idx[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};

  initial begin
    exp_m = 8'b10110100;
    exp_l = 8'b00101101;

    // Reset state
    tick(3);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_out",   32'(m_out),   32'd0);
    chk("rst_ready", 32'(m_ready), 32'd1);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(2);

    // Single frame 8'hB4, both bit orders
    send(8'hB4);
    tick(9);
    for (int unsigned k = 1; k <= 8; k++) begin
      chk("t1_out_msb", 32'(tr[k].om), 32'(exp_m[k-1]));
      chk("t2_out_lsb", 32'(tr[k].ol), 32'(exp_l[k-1]));
      chk("t1_valid",   32'(tr[k].v),  32'd1);
      chk("t1_fs",      32'(tr[k].fs), 32'(k == 1));
      chk("t1_fl",      32'(tr[k].fl), 32'(k == 8));
    end
    chk("t1_idle_after", 32'(tr[9].v), 32'd0);
    tick(2);

    // Back-to-back FF then 00 via the holding buffer
    tr.delete();
    data_in    = 8'hFF;
    load_valid = 1'b1;
    tick();
    data_in = 8'h00;
    tick();
    load_valid = 1'b0;
    tick(15);
    for (int unsigned k = 1; k <= 16; k++) begin
      chk("t3_valid", 32'(tr[k].v),  32'd1);
      chk("t3_out",   32'(tr[k].om), 32'(k <= 8));
      chk("t3_ready", 32'(tr[k].lr), 32'(k == 1 || k >= 9));
    end
    chk("t3_idle_after", 32'(tr[17].v), 32'd0);
    tick(2);

    // Stall for three edges while bit 2 is on the line
    send(8'hB4);
    tick(2);
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(7);
    for (int unsigned k = 1; k <= 11; k++) begin
      chk("t4_out", 32'(tr[k].om), 32'(exp_m[stall_idx[k-1]]));
      chk("t4_fs",  32'(tr[k].fs), 32'(k == 1));
      chk("t4_fl",  32'(tr[k].fl), 32'(k == 11));
    end
    chk("t4_idle_after", 32'(tr[12].v), 32'd0);
    tick(2);

    // Bypass on frame_last with empty buffer
    send(8'hB4);
    tick(7);
    data_in    = 8'h81;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(9);
    chk("t5_last",     32'(tr[8].fl),  32'd1);
    chk("t5_next_v",   32'(tr[9].v),   32'd1);
    chk("t5_next_fs",  32'(tr[9].fs),  32'd1);
    chk("t5_next_om",  32'(tr[9].om),  32'd1);
    chk("t5_next_ol",  32'(tr[9].ol),  32'd1);
    chk("t5_mid_om",   32'(tr[10].om), 32'd0);
    chk("t5_end_fl",   32'(tr[16].fl), 32'd1);
    chk("t5_idle",     32'(tr[17].v),  32'd0);
    tick(2);

    // Reset while bit 4 of 8'hB4 is on the line
    send(8'hB4);
    tick(4);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_out",   32'(m_out),   32'd0);
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_fs",    32'(m_fs),    32'd0);
    chk("t6_fl",    32'(l_fl),    32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_ready", 32'(m_ready), 32'd1);
    chk("t6_quiet", 32'(m_valid), 32'd0);

    // Randomised traffic with occasional stalls and resets
    for (int unsigned c = 0; c < 4000; c++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      data_in    = W'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
    end
    load_valid = 1'b0;
    enable     = 1'b1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
